// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller (mc_ctrl_fsm).
// Opcode classes, ALU op codes and datapath mux encodings live here.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_BRANCH,
    CL_JUMP,
    CL_IMM,
    CL_LOAD,
    CL_STORE,
    CL_ILLEGAL
  } op_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_ORI   = 3'b100;
  localparam logic [2:0] ALU_BNE   = 3'b101;
  localparam logic [2:0] ALU_SLTIU = 3'b110;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_TGT  = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP = 2'd2;

  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e c;
    c = CL_ILLEGAL;
    case (op)
      OP_RTYPE:                        c = CL_R;
      OP_BEQ, OP_BNE:                  c = CL_BRANCH;
      OP_J:                            c = CL_JUMP;
      OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI: c = CL_IMM;
      OP_LW:                           c = CL_LOAD;
      OP_SW:                           c = CL_STORE;
      default:                         c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decode for mc_ctrl_fsm: class, ALU op, immediate
// extension and branch sense for the latched opcode.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output logic [2:0] cls_o,
  output logic [2:0] alu_op_o,
  output logic       se_o,
  output logic       br_ne_o
);

  assign cls_o = op_class(op_i);

  always_comb begin
    alu_op_o = ALU_ADD;
    se_o     = 1'b1;
    br_ne_o  = 1'b0;
    case (op_i)
      OP_SLTIU: begin
        alu_op_o = ALU_SLTIU;
        se_o     = 1'b0;
      end
      OP_ORI:  alu_op_o = ALU_ORI;
      OP_LUI:  alu_op_o = ALU_LUI;
      OP_BEQ: begin
        alu_op_o = ALU_SUB;
        se_o     = 1'b0;
      end
      OP_BNE: begin
        alu_op_o = ALU_BNE;
        se_o     = 1'b0;
        br_ne_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle instruction sequencer with retire counter and memory-wait watchdog.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap and hang until reset.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned RETIRE_W = 32,
  parameter int unsigned MEM_TMO  = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                mem_ready_i,
  input  logic                zero_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                se_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic [RETIRE_W-1:0] retired_o,
  output logic                mem_err_o,
  output logic                trap_o
);

  // state    | meaning
  // FETCH    | read instr, PC+4 ; DECODE | latch op, branch target
  // EXEC_*/WB_* | ALU then regfile write ; ADDR/MEM_*/WB_MEM | load/store
  // BRANCH/JUMP | PC redirect ; ILLEGAL | NOP or trap (build option)

  state_e              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                mem_err_q, mem_err_d;

  logic [2:0] dec_cls;
  logic [2:0] dec_alu_op;
  logic       dec_se;
  logic       dec_br_ne;
  logic [2:0] alu_op3;
  logic       waiting;

  mc_op_decode u_dec (
    .op_i     (op_q),
    .cls_o    (dec_cls),
    .alu_op_o (dec_alu_op),
    .se_o     (dec_se),
    .br_ne_o  (dec_br_ne)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_class(instr_op_i))
          CL_R:      state_d = S_EXEC_R;
          CL_BRANCH: state_d = S_BRANCH;
          CL_JUMP:   state_d = S_JUMP;
          CL_IMM:    state_d = S_EXEC_I;
          CL_LOAD,
          CL_STORE:  state_d = S_ADDR;
          default:   state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_I:   state_d = S_FETCH;
      S_ADDR:   state_d = (dec_cls == 3'(CL_STORE)) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready_i) state_d = S_WB_MEM;
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: if (mem_ready_i) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`else
      S_ILLEGAL: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are forced to their idle values while rst_i is high so a reset
  // landing mid-instruction never lets a write strobe through.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SRC_ALU;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRC_B_RT;
    alu_op3      = ALU_FUNCT;
    se_o         = 1'b1;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          alu_src_b_o = SRC_B_FOUR;
          alu_op3     = ALU_ADD;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            pc_src_o   = PC_SRC_ALU;
          end
        end
        S_DECODE: begin
          alu_src_b_o = SRC_B_IMM_SH;
          alu_op3     = ALU_ADD;
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRC_B_RT;
          alu_op3     = ALU_FUNCT;
        end
        S_WB_R: begin
          reg_dst_o   = 1'b1;
          reg_write_o = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRC_B_IMM;
          alu_op3     = dec_alu_op;
          se_o        = dec_se;
        end
        S_WB_I:   reg_write_o = 1'b1;
        S_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRC_B_IMM;
          alu_op3     = ALU_ADD;
        end
        S_MEM_RD: mem_req_o = 1'b1;
        S_WB_MEM: begin
          mem_to_reg_o = 1'b1;
          reg_write_o  = 1'b1;
        end
        S_MEM_WR: begin
          mem_req_o = 1'b1;
          mem_we_o  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRC_B_RT;
          alu_op3     = dec_alu_op;
          se_o        = dec_se;
          // zero_i reports rs==rt, so bne is taken when it is low
          if (zero_i ^ dec_br_ne) begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_SRC_TGT;
          end
        end
        S_JUMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = PC_SRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign alu_op_o = ALU_OP_W'(alu_op3);

  always_comb begin
    op_d       = (state_q == S_DECODE) ? instr_op_i : op_q;
    waiting    = mem_req_o && !mem_ready_i;
    wait_cnt_d = 8'd0;
    if (waiting) wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
    mem_err_d  = mem_err_q || (wait_cnt_d == 8'(MEM_TMO));
    retired_d  = retired_q;
    if (state_q != S_FETCH && state_d == S_FETCH) retired_d = retired_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign retired_o = retired_q;
  assign mem_err_o = mem_err_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign trap_o = !rst_i && (state_q == S_ILLEGAL);
`else
  assign trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (narrow retire counter to reach wrap).
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op;
  logic          rdy;
  logic          zr;
  logic          mem_req, mem_we, ir_write, pc_write;
  logic [1:0]    pc_src;
  logic          src_a;
  logic [1:0]    src_b;
  logic [2:0]    alu_op;
  logic          se, reg_dst, mem_to_reg, reg_write;
  logic [RW-1:0] retired;
  logic          mem_err, trap;

  logic [RW-1:0] exp_ret;
  int            total = 0;
  int            passed = 0;
  int            failed = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALU_OP_W(3), .RETIRE_W(RW), .MEM_TMO(15)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_op_i   (op),
    .mem_ready_i  (rdy),
    .zero_i       (zr),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .alu_src_a_o  (src_a),
    .alu_src_b_o  (src_b),
    .alu_op_o     (alu_op),
    .se_o         (se),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .retired_o    (retired),
    .mem_err_o    (mem_err),
    .trap_o       (trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle at the falling edge, then sample outputs.
  task automatic tick(input logic r, input logic z);
    @(negedge clk);
    rdy = r;
    zr  = z;
    #1;
  endtask

  task automatic do_fetch(input string tag);
    tick(1'b1, 1'b0);
    chk({tag, "_f_req"}, 32'(mem_req), 1);
    chk({tag, "_f_ir"}, 32'(ir_write), 1);
    chk({tag, "_f_pcw"}, 32'(pc_write), 1);
    chk({tag, "_f_srcb"}, 32'(src_b), 1);
    chk({tag, "_f_ret"}, 32'(retired), 32'(exp_ret));
  endtask

  task automatic do_decode(input string tag);
    tick(1'b1, 1'b0);
    chk({tag, "_d_srcb"}, 32'(src_b), 3);
    chk({tag, "_d_req"}, 32'(mem_req), 0);
  endtask

  initial begin
    rst = 1'b1; op = 6'd0; rdy = 1'b1; zr = 1'b0; exp_ret = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_ir", 32'(ir_write), 0);
    chk("rst_srcb", 32'(src_b), 0);
    chk("rst_aluop", 32'(alu_op), 0);
    chk("rst_se", 32'(se), 1);
    chk("rst_ret", 32'(retired), 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_trap", 32'(trap), 0);
    @(posedge clk); #1 rst = 1'b0;

    // addi: F D EI WI, register write only in the fourth cycle
    op = OP_ADDI;
    do_fetch("addi");
    chk("addi_f_rw", 32'(reg_write), 0);
    do_decode("addi");
    chk("addi_d_rw", 32'(reg_write), 0);
    tick(1'b1, 1'b0);
    chk("addi_e_srca", 32'(src_a), 1);
    chk("addi_e_srcb", 32'(src_b), 2);
    chk("addi_e_op", 32'(alu_op), 3'b010);
    chk("addi_e_se", 32'(se), 1);
    chk("addi_e_rw", 32'(reg_write), 0);
    tick(1'b1, 1'b0);
    chk("addi_w_rw", 32'(reg_write), 1);
    chk("addi_w_dst", 32'(reg_dst), 0);
    exp_ret++;

    op = OP_SLTIU;
    do_fetch("sltiu");
    do_decode("sltiu");
    tick(1'b1, 1'b0);
    chk("sltiu_op", 32'(alu_op), 3'b110);
    chk("sltiu_se", 32'(se), 0);
    tick(1'b1, 1'b0);
    chk("sltiu_rw", 32'(reg_write), 1);
    exp_ret++;

    op = OP_RTYPE;
    do_fetch("rtype");
    do_decode("rtype");
    tick(1'b1, 1'b0);
    chk("r_srca", 32'(src_a), 1);
    chk("r_srcb", 32'(src_b), 0);
    chk("r_op", 32'(alu_op), 0);
    tick(1'b1, 1'b0);
    chk("r_rw", 32'(reg_write), 1);
    chk("r_dst", 32'(reg_dst), 1);
    exp_ret++;

    // lw with three stall cycles in MEM_RD: 8 cycles total
    op = OP_LW;
    do_fetch("lw");
    do_decode("lw");
    tick(1'b1, 1'b0);
    chk("lw_a_srcb", 32'(src_b), 2);
    chk("lw_a_op", 32'(alu_op), 3'b010);
    chk("lw_a_req", 32'(mem_req), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      chk("lw_m_req", 32'(mem_req), 1);
      chk("lw_m_we", 32'(mem_we), 0);
    end
    tick(1'b1, 1'b0);
    chk("lw_m_rdy_req", 32'(mem_req), 1);
    chk("lw_m_rdy_rw", 32'(reg_write), 0);
    tick(1'b1, 1'b0);
    chk("lw_wb_m2r", 32'(mem_to_reg), 1);
    chk("lw_wb_rw", 32'(reg_write), 1);
    chk("lw_wb_dst", 32'(reg_dst), 0);
    chk("lw_wb_we", 32'(mem_we), 0);
    exp_ret++;

    op = OP_BEQ;
    do_fetch("beq");
    do_decode("beq");
    tick(1'b1, 1'b1);
    chk("beq_pcw", 32'(pc_write), 1);
    chk("beq_pcsrc", 32'(pc_src), 1);
    chk("beq_op", 32'(alu_op), 3'b001);
    chk("beq_se", 32'(se), 0);
    exp_ret++;

    op = OP_BNE;
    do_fetch("bne_z1");
    do_decode("bne_z1");
    tick(1'b1, 1'b1);
    chk("bne_z1_pcw", 32'(pc_write), 0);
    chk("bne_z1_op", 32'(alu_op), 3'b101);
    exp_ret++;

    do_fetch("bne_z0");
    do_decode("bne_z0");
    tick(1'b1, 1'b0);
    chk("bne_z0_pcw", 32'(pc_write), 1);
    chk("bne_z0_pcsrc", 32'(pc_src), 1);
    exp_ret++;

    op = OP_SW;
    do_fetch("sw");
    do_decode("sw");
    tick(1'b1, 1'b0);
    chk("sw_a_we", 32'(mem_we), 0);
    tick(1'b1, 1'b0);
    chk("sw_m_we", 32'(mem_we), 1);
    chk("sw_m_req", 32'(mem_req), 1);
    exp_ret++;

    // memory never ready in FETCH for 20 cycles
    op = OP_J;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b0);
      chk("wd_req", 32'(mem_req), 1);
      chk("wd_ir", 32'(ir_write), 0);
      if (k == 15) chk("wd_err_14", 32'(mem_err), 0);
      if (k == 16) chk("wd_err_15", 32'(mem_err), 1);
      if (k == 20) chk("wd_err_19", 32'(mem_err), 1);
    end
    do_fetch("jmp");
    do_decode("jmp");
    tick(1'b1, 1'b0);
    chk("j_pcw", 32'(pc_write), 1);
    chk("j_pcsrc", 32'(pc_src), 2);
    chk("j_err_sticky", 32'(mem_err), 1);
    exp_ret++;

    op = 6'b111111;
    do_fetch("ill");
    do_decode("ill");
    tick(1'b1, 1'b0);
    chk("ill_req", 32'(mem_req), 0);
    chk("ill_pcw", 32'(pc_write), 0);
    chk("ill_rw", 32'(reg_write), 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    chk("ill_trap", 32'(trap), 1);
    repeat (3) begin
      tick(1'b1, 1'b0);
      chk("ill_stuck_trap", 32'(trap), 1);
      chk("ill_stuck_req", 32'(mem_req), 0);
      chk("ill_stuck_ret", 32'(retired), 32'(exp_ret));
    end
`else
    chk("ill_trap", 32'(trap), 0);
    exp_ret++;
    do_fetch("ill_nop");
`endif

    // reset clears counters and sticky flags
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_ret = '0;
    tick(1'b0, 1'b0);
    chk("rst2_req", 32'(mem_req), 1);
    chk("rst2_err", 32'(mem_err), 0);
    chk("rst2_trap", 32'(trap), 0);
    chk("rst2_ret", 32'(retired), 0);

    // reset landing in MEM_WR
    op = OP_SW;
    do_fetch("swr");
    do_decode("swr");
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("swr_we", 32'(mem_we), 1);
    @(negedge clk); rst = 1'b1; #1;
    chk("swr_rst_we", 32'(mem_we), 0);
    chk("swr_rst_req", 32'(mem_req), 0);
    @(posedge clk); #1 rst = 1'b0;
    tick(1'b0, 1'b0);
    chk("swr_f_req", 32'(mem_req), 1);
    chk("swr_f_srcb", 32'(src_b), 1);
    chk("swr_f_we", 32'(mem_we), 0);
    chk("swr_f_ret", 32'(retired), 0);

    // retire counter wraps after 2^RW instructions
    op = OP_J;
    for (int i = 0; i < 16; i++) begin
      do_fetch("wrap");
      do_decode("wrap");
      tick(1'b1, 1'b0);
      chk("wrap_j_pcw", 32'(pc_write), 1);
      exp_ret++;
    end
    chk("wrap_exp_zero", 32'(exp_ret), 0);
    do_fetch("wrap_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
